// File: rtl/debounce_multi.sv
// Multi-channel push-button debouncer: 2-flop synchroniser, tick-gated stability counter and
// registered rise/fall pulses per channel. Optional long-press detector under DEBOUNCE_LONGPRESS_EN.
module debounce_multi #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned LONG_CYCLES   = 1024,
  parameter bit          IDLE_LEVEL    = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] pb_in,
  input  logic                tick_en,
  output logic [CHANNELS-1:0] pb_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] long_press
);

  localparam int unsigned     CntW   = $clog2(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  if (CHANNELS < 1 || STABLE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_bad_params
    $error("debounce_multi: invalid parameter value");
  end

  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CHANNELS-1:0] pb_q, pb_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic [CntW-1:0]     cnt_q [CHANNELS];
  logic [CntW-1:0]     cnt_d [CHANNELS];

  // Any agreement between synchronised input and output discards the partial count.
  always_comb begin
    pb_d   = pb_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == pb_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick_en) begin
        if (cnt_q[i] == CntMax) begin
          cnt_d[i]  = '0;
          pb_d[i]   = sync2_q[i];
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= {CHANNELS{IDLE_LEVEL}};
      sync2_q <= {CHANNELS{IDLE_LEVEL}};
      pb_q    <= {CHANNELS{IDLE_LEVEL}};
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= pb_in;
      sync2_q <= sync1_q;
      pb_q    <= pb_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign pb_out     = pb_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam int unsigned      HoldW   = $clog2(LONG_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_CYCLES);

  logic [HoldW-1:0]    hold_q [CHANNELS];
  logic [HoldW-1:0]    hold_d [CHANNELS];
  logic [CHANNELS-1:0] long_q, long_d;

  // Saturating at HoldMax gives one pulse per press; release clears and re-arms.
  always_comb begin
    long_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hold_d[i] = hold_q[i];
      if (pb_q[i] == IDLE_LEVEL) begin
        hold_d[i] = '0;
      end else if (tick_en && (hold_q[i] != HoldMax)) begin
        hold_d[i] = hold_q[i] + HoldW'(1);
        long_d[i] = (hold_q[i] == HoldMax - HoldW'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      long_q <= long_d;
      for (int i = 0; i < CHANNELS; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign long_press = long_q;
`else
  assign long_press = '0;
`endif

endmodule

// File: doc/debounce_multi.md
# debounce_multi

Parametrised multi-channel push-button debouncer, the successor to the single-button `debouncing` block. Each channel has a 2-flop synchroniser, a stability counter gated by an optional sample tick, and one-cycle rise/fall event pulses. An optional long-press detector can be compiled in. The block sits between raw board buttons and the control logic, runs on the system clock, and creates no derived clocks.

## Interface
- `CHANNELS`, 4: number of independent button channels (≥1).
- `STABLE_CYCLES`, 16: number of consecutive qualifying ticks a new level must hold before it is accepted (≥2).
- `LONG_CYCLES`, 1024: ticks the debounced level must stay active before `long_press` fires (≥1; used only with the macro).
- `IDLE_LEVEL`, 0: released level of the buttons (0 or 1). Reset value of the synchronisers and `pb_out`.

- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pb_in` in CHANNELS: raw asynchronous button inputs.
- `tick_en` in 1: sample-enable strobe for the counters; tie to 1 for per-clock sampling.
- `pb_out` out CHANNELS: debounced level.
- `rise_pulse` out CHANNELS: one-cycle pulse when `pb_out` goes 0→1.
- `fall_pulse` out CHANNELS: one-cycle pulse when `pb_out` goes 1→0.
- `long_press` out CHANNELS: one-cycle pulse when a long press is detected; constant 0 if the feature is compiled out.

## Operation
- **Reset values:** while `rst_n`=0, the synchronisers and `pb_out` are set to `IDLE_LEVEL`. All counters, `rise_pulse`, `fall_pulse` and `long_press` are 0.
- **Per-channel datapath:** `pb_in` → sync1 → sync2 (`s`). Stability counter `cnt` is `$clog2(STABLE_CYCLES)` bits wide.
- **Counter rules, evaluated every clock:**
  - If `s == pb_out`: `cnt`←0, regardless of `tick_en`.
  - Else if `tick_en`=0: hold.
  - Else if `cnt == STABLE_CYCLES-1`: `pb_out`←`s` and `cnt`←0.
  - Else: `cnt`←`cnt`+1.
- **Glitch rejection:** any return of `s` to the `pb_out` level before acceptance clears `cnt`. A bounce shorter than `STABLE_CYCLES` ticks never changes `pb_out`.
- **Event pulses:**
  - `rise_pulse[i]` is registered and asserted for exactly one clock, in the same cycle `pb_out[i]` first shows 1.
  - `fall_pulse[i]` is the same for 0.
  - Both pulses are never high together on one channel.
- **Channel independence:** channels share only `clk`, `rst_n` and `tick_en`. Simultaneous transitions on several channels are handled independently.

## Timing
- With `tick_en`=1: input edge sampled at clock edge k gives `pb_out`/pulse at edge k+1+`STABLE_CYCLES`. This is a latency of `STABLE_CYCLES`+2 edges.
- With `tick_en` asserted every N clocks, the counting part scales to about N×(`STABLE_CYCLES`); synchroniser latency stays at 2 clocks.
- `rst_n` asserted mid-count: outputs go to their reset values immediately and asynchronously, and any partial count is discarded. After deassertion, a held-active input needs the full latency again.
- Deassert `rst_n` synchronously to `clk` externally. The block does not resynchronise reset.

## Configuration
- Macro `DEBOUNCE_LONGPRESS_EN`.
- **Defined:**
  - Each channel gets a hold counter of `$clog2(LONG_CYCLES+1)` bits.
  - The counter clears whenever `pb_out[i]` == `IDLE_LEVEL`.
  - Otherwise it increments on `tick_en` and saturates at `LONG_CYCLES`.
  - `long_press[i]` pulses for one clock on the cycle the counter reaches `LONG_CYCLES`. It is at most one pulse per press and re-arms only after release.
- **Undefined:** no hold counters are built and `long_press` is driven constant 0.

## Test plan
Bench configuration: `CHANNELS`=2, `STABLE_CYCLES`=4, `LONG_CYCLES`=8, `IDLE_LEVEL`=0, 20 ns `clk`, `tick_en`=1 unless stated.

1. **Reset:** hold `rst_n`=0 with `pb_in`=2'b11 → `pb_out`=0 and all pulses 0 throughout; `pb_out[0]`=1 exactly 6 edges after release.
2. **Bounce train on ch0:** 1-clock low glitches inside highs of 1–3 clocks → `pb_out[0]` stays 0. After the last glitch, the input held high → `pb_out[0]`=1 at edge 6 with a single `rise_pulse[0]`. `fall_pulse` is never asserted.
3. **Long press** (macro defined): ch0 held high for 30 clocks → `long_press[0]` one pulse 8 clocks after `pb_out[0]` rises, no repeat. Release → `fall_pulse[0]` one pulse. With the macro undefined → `long_press`=0 always.
4. **Tick gating:** `tick_en` high 1 clock in 4; ch1 steps 0→1 → `pb_out[1]` changes after 2 + 4×4 = 18 ±3 clocks. A 10-clock high pulse is rejected.
5. **Simultaneous channels:** ch0 rises while ch1 falls on the same edge → `rise_pulse[0]` and `fall_pulse[1]` in the same cycle; no cross-coupling.
6. **Reset mid-count:** `rst_n` pulsed low when ch0 `cnt`=2 → `pb_out[0]` stays 0, and the full 6-edge latency is observed after release.
